// File: rtl/ifft_butterfly_if.sv
// Sample/twiddle bus for the inverse radix-2 butterfly, with valid/ready on both sides.
interface ifft_butterfly_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
);
    logic                    data_valid_in;
    logic                    in_ready;
    logic signed [IN_W-1:0]  a_i, a_q;
    logic signed [IN_W-1:0]  b_i, b_q;
    logic signed [IN_W-1:0]  w_i, w_q;
    logic signed [OUT_W-1:0] x_i, x_q;
    logic signed [OUT_W-1:0] y_i, y_q;
    logic                    data_valid_out;
    logic                    out_ready;

    modport master (
        output data_valid_in, a_i, a_q, b_i, b_q, w_i, w_q, out_ready,
        input  in_ready, x_i, x_q, y_i, y_q, data_valid_out
    );

    modport slave (
        input  data_valid_in, a_i, a_q, b_i, b_q, w_i, w_q, out_ready,
        output in_ready, x_i, x_q, y_i, y_q, data_valid_out
    );
endinterface

// File: rtl/ifft_butterfly_unit.sv
// Gentleman-Sande inverse butterfly: X = A + B, Y = (A - B) * conj(W).
// Three-stage pipeline stalled as a whole by a single enable from the output side.
module ifft_butterfly_unit #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    ifft_butterfly_if.slave bus
);
    localparam int unsigned SW   = IN_W + 1;
    localparam int unsigned PW   = 2 * IN_W + 1;
    localparam int unsigned SUMW = 2 * IN_W + 2;
    // Headroom for the rounding add and for holding the saturation limits.
    localparam int unsigned CW   = (SUMW + 1 > OUT_W + 1) ? SUMW + 1 : OUT_W + 1;

    localparam logic signed [CW-1:0] RND     = CW'((2 ** SHIFT) / 2);
    localparam logic signed [CW-1:0] SAT_MAX = {{(CW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [CW-1:0] SAT_MIN = {{(CW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic                    en;
    logic                    v1, v2, v3;
    logic signed [SW-1:0]    s1_i, s1_q, d1_i, d1_q;
    logic signed [IN_W-1:0]  w1_i, w1_q;
    logic signed [SW-1:0]    s2_i, s2_q;
    logic signed [PW-1:0]    p_ii, p_qq, p_qi, p_iq;
    logic signed [OUT_W-1:0] x_i_r, x_q_r, y_i_r, y_q_r;

    // Round half up by SHIFT, then clamp to the signed OUT_W range.
    function automatic logic signed [OUT_W-1:0] rnd_sat(input logic signed [SUMW-1:0] v);
        logic signed [CW-1:0] t;
        t = CW'(v);
        t = (t + RND) >>> SHIFT;
        if (t > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
        else if (t < SAT_MIN) return SAT_MIN[OUT_W-1:0];
        else                  return t[OUT_W-1:0];
    endfunction

    assign en                 = ~v3 | bus.out_ready;
    assign bus.in_ready       = en;
    assign bus.data_valid_out = v3;
    assign bus.x_i            = x_i_r;
    assign bus.x_q            = x_q_r;
    assign bus.y_i            = y_i_r;
    assign bus.y_q            = y_q_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1    <= 1'b0;
            v2    <= 1'b0;
            v3    <= 1'b0;
            s1_i  <= '0;
            s1_q  <= '0;
            d1_i  <= '0;
            d1_q  <= '0;
            w1_i  <= '0;
            w1_q  <= '0;
            s2_i  <= '0;
            s2_q  <= '0;
            p_ii  <= '0;
            p_qq  <= '0;
            p_qi  <= '0;
            p_iq  <= '0;
            x_i_r <= '0;
            x_q_r <= '0;
            y_i_r <= '0;
            y_q_r <= '0;
        end else if (en) begin
            // S1: exact sum/difference, twiddle passes through
            v1    <= bus.data_valid_in;
            s1_i  <= SW'(bus.a_i) + SW'(bus.b_i);
            s1_q  <= SW'(bus.a_q) + SW'(bus.b_q);
            d1_i  <= SW'(bus.a_i) - SW'(bus.b_i);
            d1_q  <= SW'(bus.a_q) - SW'(bus.b_q);
            w1_i  <= bus.w_i;
            w1_q  <= bus.w_q;
            // S2: four exact partial products
            v2    <= v1;
            s2_i  <= s1_i;
            s2_q  <= s1_q;
            p_ii  <= PW'(d1_i) * PW'(w1_i);
            p_qq  <= PW'(d1_q) * PW'(w1_q);
            p_qi  <= PW'(d1_q) * PW'(w1_i);
            p_iq  <= PW'(d1_i) * PW'(w1_q);
            // S3: conjugate combine, round/saturate Y; X is plain sign extension
            v3    <= v2;
            x_i_r <= OUT_W'(s2_i);
            x_q_r <= OUT_W'(s2_q);
            y_i_r <= rnd_sat(SUMW'(p_ii) + SUMW'(p_qq));
            y_q_r <= rnd_sat(SUMW'(p_qi) - SUMW'(p_iq));
        end
    end
endmodule
